// File: rtl/mipi_csi_tx_packet_encoder_8b4lane_if.sv
// ---------------------------------------------------------------------------
// mipi_csi_tx_packet_encoder_8b4lane_if
// Bundles the packet-request, payload-stream and lane-output signals of the
// CSI-2 TX packet encoder. Clock and reset are not part of the bundle.
//   slave  : the encoder (consumes requests and payload, drives lanes)
//   master : the packet source / lane consumer
// Signals:
//   start_i, data_id_i[7:0], word_count_i[15:0]  packet request
//   ready_o                                       encoder idle
//   payload_data_i[31:0], payload_valid_i         payload stream in
//   payload_ready_o                               payload accepted this cycle
//   data_o[31:0], lane_valid_o[3:0], data_valid_o lane bytes out
//   packet_done_o, underrun_o                     status pulses
// ---------------------------------------------------------------------------
interface mipi_csi_tx_packet_encoder_8b4lane_if;
    logic        start_i;
    logic [7:0]  data_id_i;
    logic [15:0] word_count_i;
    logic        ready_o;
    logic [31:0] payload_data_i;
    logic        payload_valid_i;
    logic        payload_ready_o;
    logic [31:0] data_o;
    logic [3:0]  lane_valid_o;
    logic        data_valid_o;
    logic        packet_done_o;
    logic        underrun_o;

    modport slave (
        input  start_i, data_id_i, word_count_i, payload_data_i, payload_valid_i,
        output ready_o, payload_ready_o, data_o, lane_valid_o, data_valid_o,
               packet_done_o, underrun_o
    );

    modport master (
        output start_i, data_id_i, word_count_i, payload_data_i, payload_valid_i,
        input  ready_o, payload_ready_o, data_o, lane_valid_o, data_valid_o,
               packet_done_o, underrun_o
    );
endinterface

// File: rtl/mipi_csi_tx_packet_encoder_8b4lane.sv
// ---------------------------------------------------------------------------
// mipi_csi_tx_packet_encoder_8b4lane
// Builds CSI-2 packets on a 4-lane x 8-bit byte interface: sync word,
// ECC-protected header, lane-packed payload and CRC-16 footer, with per-lane
// byte enables. All outputs are registered.
// Ports:
//   clk_i      MIPI byte clock
//   reset_n_i  synchronous active-low reset
//   bus        slave side of mipi_csi_tx_packet_encoder_8b4lane_if
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | ready_o=1, waiting for start_i
// S_SYNC    | sync word on data_o
// S_HDR     | packet header on data_o
// S_PAYLOAD | payload_ready_o=1 while bytes remain; once r_rem=0 the final
//           | (possibly CRC-merged) word is on data_o
// S_FOOT    | separate CRC footer word on data_o
// S_GAP     | one idle trail cycle before returning to S_IDLE
// ---------------------------------------------------------------------------
module mipi_csi_tx_packet_encoder_8b4lane #(
    parameter int         LANES     = 4,
    parameter int         MIPI_GEAR = 8,
    parameter logic [7:0] SYNC_BYTE = 8'hB8
) (
    input  logic clk_i,
    input  logic reset_n_i,
    mipi_csi_tx_packet_encoder_8b4lane_if.slave bus
);
    localparam int W = LANES * MIPI_GEAR;

    typedef enum logic [2:0] {
        S_IDLE, S_SYNC, S_HDR, S_PAYLOAD, S_FOOT, S_GAP
    } state_t;

    state_t         r_state, w_state_nx;
    logic [7:0]     r_di;
    logic [15:0]    r_wc;
    logic [16:0]    r_rem, w_rem_nx, w_rem_dec;
    logic [15:0]    r_crc, w_crc_nx, w_crc_upd;
    logic [W-1:0]   r_data, w_data_nx;
    logic [LANES-1:0] r_lane_valid, w_lv_nx;
    logic           r_data_valid, r_done, w_done_nx, r_underrun, w_und_nx;
    logic           r_pready, w_pready_nx, r_ready, w_ready_nx;
    logic           w_latch, w_short, w_accept, w_last;
    logic [2:0]     w_nbytes;
    logic [7:0]     w_ecc;

    // CSI-2 Hamming parity: each mask selects the header bits feeding one parity bit.
    function automatic logic [7:0] f_ecc(input logic [23:0] d);
        return {2'b00, ^(d & 24'hEFFC00), ^(d & 24'hDF03F0), ^(d & 24'hB8E38E),
                ^(d & 24'h749A6D), ^(d & 24'hF2555B), ^(d & 24'hF12CB7)};
    endfunction

    // Reflected CRC-16 (0x1021 -> 0x8408), byte 0 first, only the first n bytes.
    function automatic logic [15:0] f_crc(input logic [15:0] crc_in,
                                          input logic [31:0] bytes,
                                          input logic [2:0]  n);
        logic [15:0] c;
        c = crc_in;
        for (int b = 0; b < 4; b++) begin
            if (3'(b) < n) begin
                c = c ^ {8'h00, bytes[8*b +: 8]};
                for (int k = 0; k < 8; k++)
                    c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
            end
        end
        return c;
    endfunction

    assign w_short   = (r_di[5:0] < 6'h10);
    assign w_ecc     = f_ecc({r_wc, r_di});
    assign w_nbytes  = (r_rem >= 17'd4) ? 3'd4 : r_rem[2:0];
    assign w_accept  = r_pready & bus.payload_valid_i;
    assign w_last    = (r_rem <= 17'd4);
    assign w_crc_upd = f_crc(r_crc, bus.payload_data_i, w_nbytes);
    assign w_rem_dec = (r_rem > {14'd0, w_nbytes}) ? (r_rem - {14'd0, w_nbytes}) : 17'd0;

    always_comb begin
        w_state_nx  = r_state;
        w_data_nx   = '0;
        w_lv_nx     = '0;
        w_done_nx   = 1'b0;
        w_und_nx    = 1'b0;
        w_pready_nx = 1'b0;
        w_ready_nx  = 1'b0;
        w_crc_nx    = r_crc;
        w_rem_nx    = r_rem;
        w_latch     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready_nx = 1'b1;
                if (bus.start_i) begin
                    w_latch    = 1'b1;
                    w_state_nx = S_SYNC;
                    w_data_nx  = {4{SYNC_BYTE}};
                    w_lv_nx    = 4'hF;
                    w_ready_nx = 1'b0;
                    w_crc_nx   = 16'hFFFF;
                    w_rem_nx   = {1'b0, bus.word_count_i};
                end
            end
            S_SYNC: begin
                w_state_nx = S_HDR;
                w_data_nx  = {w_ecc, r_wc[15:8], r_wc[7:0], r_di};
                w_lv_nx    = 4'hF;
                w_done_nx  = w_short;
            end
            S_HDR: begin
                if (w_short) begin
                    w_state_nx = S_GAP;
                end else if (r_wc == 16'd0) begin
                    w_state_nx = S_FOOT;
                    w_data_nx  = {16'h0000, r_crc};
                    w_lv_nx    = 4'h3;
                    w_done_nx  = 1'b1;
                end else begin
                    w_state_nx  = S_PAYLOAD;
                    w_pready_nx = 1'b1;
                end
            end
            S_PAYLOAD: begin
                if (r_rem == 17'd0) begin
                    // Final word is on the lanes; emit whatever CRC did not fit in it.
                    if (r_wc[1:0] == 2'd0) begin
                        w_state_nx = S_FOOT;
                        w_data_nx  = {16'h0000, r_crc};
                        w_lv_nx    = 4'h3;
                        w_done_nx  = 1'b1;
                    end else if (r_wc[1:0] == 2'd3) begin
                        w_state_nx = S_FOOT;
                        w_data_nx  = {24'h000000, r_crc[15:8]};
                        w_lv_nx    = 4'h1;
                        w_done_nx  = 1'b1;
                    end else begin
                        w_state_nx = S_GAP;
                    end
                end else begin
                    w_pready_nx = 1'b1;
                    if (w_accept) begin
                        w_crc_nx  = w_crc_upd;
                        w_rem_nx  = w_rem_dec;
                        w_data_nx = bus.payload_data_i;
                        w_lv_nx   = 4'hF;
                        if (w_last) begin
                            w_pready_nx = 1'b0;
                            case (r_wc[1:0])
                                2'd1: begin
                                    w_data_nx = {8'h00, w_crc_upd, bus.payload_data_i[7:0]};
                                    w_lv_nx   = 4'h7;
                                    w_done_nx = 1'b1;
                                end
                                2'd2: begin
                                    w_data_nx = {w_crc_upd, bus.payload_data_i[15:0]};
                                    w_done_nx = 1'b1;
                                end
                                2'd3: w_data_nx = {w_crc_upd[7:0], bus.payload_data_i[23:0]};
                                default: ;
                            endcase
                        end
                    end else begin
                        w_und_nx = 1'b1;
                    end
                end
            end
            S_FOOT: w_state_nx = S_GAP;
            S_GAP: begin
                w_state_nx = S_IDLE;
                w_ready_nx = 1'b1;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_state      <= S_IDLE;
            r_di         <= '0;
            r_wc         <= '0;
            r_rem        <= '0;
            r_crc        <= 16'hFFFF;
            r_data       <= '0;
            r_lane_valid <= '0;
            r_data_valid <= 1'b0;
            r_done       <= 1'b0;
            r_underrun   <= 1'b0;
            r_pready     <= 1'b0;
            r_ready      <= 1'b1;
        end else begin
            r_state      <= w_state_nx;
            r_rem        <= w_rem_nx;
            r_crc        <= w_crc_nx;
            r_data       <= w_data_nx;
            r_lane_valid <= w_lv_nx;
            r_data_valid <= |w_lv_nx;
            r_done       <= w_done_nx;
            r_underrun   <= w_und_nx;
            r_pready     <= w_pready_nx;
            r_ready      <= w_ready_nx;
            if (w_latch) begin
                r_di <= bus.data_id_i;
                r_wc <= bus.word_count_i;
            end
        end
    end

    assign bus.data_o          = r_data;
    assign bus.lane_valid_o    = r_lane_valid;
    assign bus.data_valid_o    = r_data_valid;
    assign bus.packet_done_o   = r_done;
    assign bus.underrun_o      = r_underrun;
    assign bus.payload_ready_o = r_pready;
    assign bus.ready_o         = r_ready;
endmodule
